// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, 2 async read ports, 1 sync write port.
// A hardware sequencer zeroes every entry after reset before ready is raised.
module regfile_param #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWrite,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] write_data,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            ready,
   output logic            clr_busy
);
   localparam logic [AW:0]   N    = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST = AW'(NREGS-1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state;
   logic [AW-1:0]     clr_idx;
   logic [XLEN-1:0]   mem [NREGS];
   logic              wr_ok;

   function automatic logic legal(input logic [AW-1:0] a);
      return ({1'b0, a} < N) && !(ZERO_REG != 0 && a == '0);
   endfunction

   function automatic logic [XLEN-1:0] rd_mux(input logic [AW-1:0] a, input logic rdy, input logic wok,
                                              input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                              input logic [XLEN-1:0] stored);
      return (!rdy || !legal(a)) ? '0 : (BYPASS != 0 && wok && wa == a) ? wd : stored;
   endfunction

   assign wr_ok    = ready && RegWrite && legal(rd_addr);
   assign clr_busy = ~ready;

   always_comb begin
      rs1_data = rd_mux(rs1_addr, ready, wr_ok, rd_addr, write_data, mem[rs1_addr]);
      rs2_data = rd_mux(rs2_addr, ready, wr_ok, rd_addr, write_data, mem[rs2_addr]);
   end

   // Memory is never reset directly; only the CLEAR walk defines its contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else if (state == CLEAR) begin
         mem[clr_idx] <= '0;
         clr_idx      <= clr_idx + AW'(1);
         if (clr_idx == LAST) begin
            state <= READY;
            ready <= 1'b1;
         end
      end else if (wr_ok) begin
         mem[rd_addr] <= write_data;
      end
   end
endmodule
